// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared video timing constants and the pixel feeder state type. The same
// H_DISP/V_DISP defaults feed the RGB timing driver, so both blocks agree on
// the frame size.
// -----------------------------------------------------------------------------
package video_pkg;

    localparam int unsigned H_DISP    = 800;
    localparam int unsigned V_DISP    = 600;
    localparam int unsigned PIX_TOTAL = H_DISP * V_DISP;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/video_pixel_feeder_if.sv
// -----------------------------------------------------------------------------
// video_pixel_feeder_if
// Bundles the loader write port, the driver request/data port and the status
// outputs of video_pixel_feeder.
//   slave  : feeder view (loader/driver strobes in, pixel data and status out)
//   master : environment view (loader/driver strobes out, pixel data and status in)
// -----------------------------------------------------------------------------
interface video_pixel_feeder_if #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned FIFO_AW = 10
);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_full;
    logic [FIFO_AW:0]  fifo_level;
    logic              data_req;
    logic              video_vs;
    logic [DATA_W-1:0] pixel_data;
    logic              frame_start;
    logic [15:0]       underflow_cnt;
    logic              overflow;
    logic              sync_err;

    modport master (
        output wr_en, wr_data, data_req, video_vs,
        input  wr_full, fifo_level, pixel_data, frame_start,
               underflow_cnt, overflow, sync_err
    );

    modport slave (
        input  wr_en, wr_data, data_req, video_vs,
        output wr_full, fifo_level, pixel_data, frame_start,
               underflow_cnt, overflow, sync_err
    );

endinterface

// File: rtl/sync_fifo_1clk.sv
// -----------------------------------------------------------------------------
// sync_fifo_1clk
// Single-clock FIFO, depth 2**FIFO_AW, registered read data.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   wr_en       push wr_data (ignored while full)
//   rd_en       pop into rd_data on the next edge (ignored while empty)
//   rd_data     registered head word; holds between pops
//   level       occupancy 0..2**FIFO_AW
//   full/empty  derived from level
// -----------------------------------------------------------------------------
module sync_fifo_1clk #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned FIFO_AW = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               rd_en,
    output logic [DATA_W-1:0]  rd_data,
    output logic [FIFO_AW:0]   level,
    output logic               full,
    output logic               empty
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [FIFO_AW:0]  wr_ptr;
    logic [FIFO_AW:0]  rd_ptr;
    logic              do_wr;
    logic              do_rd;

    // Pointers carry one extra MSB, so the difference spans 0..DEPTH and the
    // MSB of the level is set exactly when the FIFO is full.
    assign level = wr_ptr - rd_ptr;
    assign full  = level[FIFO_AW];
    assign empty = (level == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr[FIFO_AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/video_pixel_feeder.sv
// -----------------------------------------------------------------------------
// video_pixel_feeder
// Buffers RGB565 words from the image loader and returns one word per driver
// data_req, one cycle later. Frames lock to the falling edge of video_vs; a
// fill colour is substituted on underflow or while not locked.
// Ports:
//   pixel_clk  sole clock
//   sys_rst_n  asynchronous active-low reset
//   bus        video_pixel_feeder_if.slave:
//              wr_en/wr_data in, wr_full/fifo_level out   (loader side)
//              data_req/video_vs in, pixel_data out       (driver side)
//              frame_start, underflow_cnt, overflow, sync_err out (status)
// -----------------------------------------------------------------------------
module video_pixel_feeder #(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       FIFO_AW     = 10,
    parameter int unsigned       H_DISP      = video_pkg::H_DISP,
    parameter int unsigned       V_DISP      = video_pkg::V_DISP,
    parameter int unsigned       PIX_W       = 20,
    parameter int unsigned       START_LEVEL = 512,
    parameter logic [DATA_W-1:0] FILL_COLOR  = '0
) (
    input logic                 pixel_clk,
    input logic                 sys_rst_n,
    video_pixel_feeder_if.slave bus
);

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(H_DISP * V_DISP - 1);

    video_pkg::feeder_state_t state;

    logic              vs_d;
    logic              vs_fall;
    logic              level_ok;
    logic              pop;
    logic [PIX_W-1:0]  pix_cnt;
    logic              frame_start;
    logic [15:0]       underflow_cnt;
    logic              overflow;
    logic              sync_err;
    logic              sel_fifo;
    logic [DATA_W-1:0] fill_word;

    logic [DATA_W-1:0] fifo_rd_data;
    logic [FIFO_AW:0]  fifo_level;
    logic              fifo_full;
    logic              fifo_empty;

    sync_fifo_1clk #(
        .DATA_W  (DATA_W),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (pixel_clk),
        .rst_n   (sys_rst_n),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign vs_fall  = vs_d & ~bus.video_vs;
    assign level_ok = (32'(fifo_level) >= START_LEVEL);
    assign pop      = (state == video_pkg::RUN) && bus.data_req && !fifo_empty;

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= video_pkg::IDLE;
            vs_d          <= 1'b1;
            pix_cnt       <= '0;
            frame_start   <= 1'b0;
            underflow_cnt <= '0;
            overflow      <= 1'b0;
            sync_err      <= 1'b0;
            sel_fifo      <= 1'b0;
            fill_word     <= '0;
        end else begin
            vs_d        <= bus.video_vs;
            frame_start <= 1'b0;

            if (bus.wr_en && fifo_full) begin
                overflow <= 1'b1;
            end

            // Output select: a pop lands in the FIFO's read register on this
            // edge, so selecting it now keeps the one-cycle latency.
            if (bus.data_req) begin
                if (pop) begin
                    sel_fifo <= 1'b1;
                end else begin
                    sel_fifo  <= 1'b0;
                    fill_word <= FILL_COLOR;
                end
            end

            case (state)
                video_pkg::IDLE: begin
                    if (vs_fall && level_ok) begin
                        state       <= video_pkg::RUN;
                        pix_cnt     <= '0;
                        frame_start <= 1'b1;
                    end
                end
                video_pkg::RUN: begin
                    if (bus.data_req) begin
                        if (fifo_empty && underflow_cnt != 16'hFFFF) begin
                            underflow_cnt <= underflow_cnt + 1'b1;
                        end
                        if (pix_cnt == PIX_LAST) begin
                            state   <= video_pkg::IDLE;
                            pix_cnt <= '0;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                    // A vsync edge inside RUN means the frame was cut short;
                    // it overrides the pixel count and any end-of-frame exit.
                    if (vs_fall) begin
                        sync_err <= 1'b1;
                        pix_cnt  <= '0;
                        if (level_ok) begin
                            state       <= video_pkg::RUN;
                            frame_start <= 1'b1;
                        end else begin
                            state <= video_pkg::IDLE;
                        end
                    end
                end
                default: state <= video_pkg::IDLE;
            endcase
        end
    end

    assign bus.pixel_data    = sel_fifo ? fifo_rd_data : fill_word;
    assign bus.wr_full       = fifo_full;
    assign bus.fifo_level    = fifo_level;
    assign bus.frame_start   = frame_start;
    assign bus.underflow_cnt = underflow_cnt;
    assign bus.overflow      = overflow;
    assign bus.sync_err      = sync_err;

endmodule

// File: tb/tb_video_pixel_feeder.sv
// -----------------------------------------------------------------------------
// tb_video_pixel_feeder
// Directed bench for video_pixel_feeder with a 4x2 frame, 16-deep FIFO and a
// start level of 4. Each request pushes its expected pixel into a queue; a
// monitor pops and compares one cycle after every request.
// -----------------------------------------------------------------------------
module tb_video_pixel_feeder;

    logic pixel_clk;
    logic sys_rst_n;

    video_pixel_feeder_if #(.DATA_W(16), .FIFO_AW(4)) bus ();

    video_pixel_feeder #(
        .DATA_W      (16),
        .FIFO_AW     (4),
        .H_DISP      (4),
        .V_DISP      (2),
        .PIX_W       (4),
        .START_LEVEL (4),
        .FILL_COLOR  (16'h0000)
    ) dut (
        .pixel_clk (pixel_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          fs_count = 0;
    logic [15:0] exp_q[$];
    logic        req_pending;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) req_pending <= 1'b0;
        else            req_pending <= bus.data_req;
    end

    always @(negedge pixel_clk) begin
        logic [15:0] e;
        if (bus.frame_start) fs_count++;
        if (req_pending) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pixel_unexpected: got 0x%0h expected none", bus.pixel_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.pixel_data !== e) begin
                    n_fail++;
                    $display("FAIL pixel_data: got 0x%0h expected 0x%0h", bus.pixel_data, e);
                end
            end
        end
    end

    task automatic write_word(input logic [15:0] v);
        bus.wr_en   = 1'b1;
        bus.wr_data = v;
        @(negedge pixel_clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic vs_pulse();
        bus.video_vs = 1'b0;
        @(negedge pixel_clk);
        bus.video_vs = 1'b1;
        @(negedge pixel_clk);
    endtask

    task automatic request(input logic [15:0] exp);
        bus.data_req = 1'b1;
        exp_q.push_back(exp);
        @(negedge pixel_clk);
        bus.data_req = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_pixel_data"},    32'(bus.pixel_data),    32'h0);
        check({tag, "_wr_full"},       32'(bus.wr_full),       32'h0);
        check({tag, "_fifo_level"},    32'(bus.fifo_level),    32'h0);
        check({tag, "_frame_start"},   32'(bus.frame_start),   32'h0);
        check({tag, "_underflow_cnt"}, 32'(bus.underflow_cnt), 32'h0);
        check({tag, "_overflow"},      32'(bus.overflow),      32'h0);
        check({tag, "_sync_err"},      32'(bus.sync_err),      32'h0);
    endtask

    initial begin
        sys_rst_n    = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        bus.data_req = 1'b0;
        bus.video_vs = 1'b1;
        repeat (2) @(negedge pixel_clk);
        check_zero_outputs("por");
        sys_rst_n = 1'b1;
        @(negedge pixel_clk);

        // 1. reset while in RUN
        for (int i = 1; i <= 4; i++) write_word(16'(16'h00A0 + i));
        vs_pulse();
        check("t1_state_run", 32'(dut.state), 32'(video_pkg::RUN));
        request(16'h00A1);
        #2 sys_rst_n = 1'b0;
        #1 check_zero_outputs("t1_rst");
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        sys_rst_n = 1'b1;
        @(negedge pixel_clk);
        check("t1_state_idle", 32'(dut.state), 32'(video_pkg::IDLE));
        check("t1_level",      32'(bus.fifo_level), 32'd0);

        // 2. full frame from a filled FIFO
        for (int i = 1; i <= 8; i++) write_word(16'(i));
        check("t2_level8", 32'(bus.fifo_level), 32'd8);
        fs_count = 0;
        vs_pulse();
        for (int i = 1; i <= 8; i++) begin
            request(16'(i));
            @(negedge pixel_clk);
        end
        check("t2_frame_start", 32'(fs_count), 32'd1);
        check("t2_state_idle",  32'(dut.state), 32'(video_pkg::IDLE));
        check("t2_level0",      32'(bus.fifo_level), 32'd0);
        check("t2_underflow",   32'(bus.underflow_cnt), 32'd0);

        // 3. underflow inside a frame
        for (int i = 0; i < 5; i++) write_word(16'(16'h0011 + i));
        fs_count = 0;
        vs_pulse();
        for (int i = 0; i < 8; i++) request(i < 5 ? 16'(16'h0011 + i) : 16'h0000);
        check("t3_underflow",   32'(bus.underflow_cnt), 32'd3);
        check("t3_state_idle",  32'(dut.state), 32'(video_pkg::IDLE));
        check("t3_frame_start", 32'(fs_count), 32'd1);

        // 4. fill to full, one extra write dropped
        for (int i = 0; i < 15; i++) write_word(16'(16'h0021 + i));
        check("t4_not_full15", 32'(bus.wr_full),    32'd0);
        check("t4_level15",    32'(bus.fifo_level), 32'd15);
        write_word(16'h0030);
        check("t4_full16",     32'(bus.wr_full),    32'd1);
        check("t4_level16",    32'(bus.fifo_level), 32'd16);
        check("t4_no_ovf_yet", 32'(bus.overflow),   32'd0);
        write_word(16'h0031);
        check("t4_overflow",   32'(bus.overflow),   32'd1);
        check("t4_level_held", 32'(bus.fifo_level), 32'd16);
        vs_pulse();
        for (int i = 0; i < 8; i++) request(16'(16'h0021 + i));
        check("t4_idle_mid", 32'(dut.state), 32'(video_pkg::IDLE));
        vs_pulse();
        for (int i = 8; i < 16; i++) request(16'(16'h0021 + i));
        check("t4_level0",    32'(bus.fifo_level),    32'd0);
        check("t4_underflow", 32'(bus.underflow_cnt), 32'd3);
        check("t4_sync_err",  32'(bus.sync_err),      32'd0);

        // 5a. vsync after 3 pixels with enough data: restart in RUN
        for (int i = 0; i < 8; i++) write_word(16'(16'h0041 + i));
        fs_count = 0;
        vs_pulse();
        for (int i = 0; i < 3; i++) request(16'(16'h0041 + i));
        check("t5_level5", 32'(bus.fifo_level), 32'd5);
        vs_pulse();
        check("t5_sync_err",    32'(bus.sync_err), 32'd1);
        check("t5_frame_start", 32'(fs_count),     32'd2);
        check("t5_state_run",   32'(dut.state),    32'(video_pkg::RUN));
        for (int i = 3; i < 8; i++) request(16'(16'h0041 + i));
        check("t5_pix_restart", 32'(dut.state), 32'(video_pkg::RUN));
        for (int i = 0; i < 3; i++) request(16'h0000);
        check("t5_state_idle", 32'(dut.state),            32'(video_pkg::IDLE));
        check("t5_underflow",  32'(bus.underflow_cnt),    32'd6);

        // 5b. vsync after 3 pixels with level 2: drop to IDLE, keep data
        for (int i = 0; i < 5; i++) write_word(16'(16'h0051 + i));
        fs_count = 0;
        vs_pulse();
        for (int i = 0; i < 3; i++) request(16'(16'h0051 + i));
        check("t5b_level2", 32'(bus.fifo_level), 32'd2);
        vs_pulse();
        check("t5b_state_idle",  32'(dut.state),      32'(video_pkg::IDLE));
        check("t5b_frame_start", 32'(fs_count),       32'd1);
        check("t5b_no_flush",    32'(bus.fifo_level), 32'd2);

        // 6. start threshold
        write_word(16'h0056);
        fs_count = 0;
        vs_pulse();
        check("t6_stay_idle", 32'(dut.state), 32'(video_pkg::IDLE));
        check("t6_no_fs",     32'(fs_count),  32'd0);
        request(16'h0000);
        check("t6_no_pop",    32'(bus.fifo_level),    32'd3);
        check("t6_underflow", 32'(bus.underflow_cnt), 32'd6);
        write_word(16'h0057);
        vs_pulse();
        check("t6_state_run", 32'(dut.state), 32'(video_pkg::RUN));
        check("t6_fs",        32'(fs_count),  32'd1);
        for (int i = 0; i < 4; i++) request(16'(16'h0054 + i));
        check("t6_level0", 32'(bus.fifo_level), 32'd0);

        @(negedge pixel_clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
